// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Writeback scheduler for a dual-write-port register file.
//                Three producers (ALU0, ALU1, load unit) post results over
//                valid/ready into per-producer FIFOs. Each cycle up to two
//                heads are merged onto the two registered write ports.
//                The two ports never target the same register. Heads that
//                target r0 are discarded without using a port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1       rising-edge clock
//    rst        in   1       asynchronous reset, active-low
//    req_valid  in   3       producer i has a result
//    req_reg    in   3*AW    destination of producer i, [i*AW +: AW]
//    req_data   in   3*DW    result of producer i, [i*DW +: DW]
//    req_ready  out  3       producer i FIFO not full (state only)
//    we1/we2    out  1       write enable, port 1 / port 2
//    wr_reg1/2  out  AW      destination, port 1 / port 2
//    wr_data1/2 out  DW      data, port 1 / port 2
//    idle       out  1       all FIFOs empty and no write in flight
//    stall_cnt  out  32      saturating stall counter (WB_STALL_CNT_EN only)
//  Build option
//    WB_STALL_CNT_EN : adds the stall_cnt output and its counter.
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req_valid,
    input  logic [3*AW-1:0]   req_reg,
    input  logic [3*DW-1:0]   req_data,
    output logic [2:0]        req_ready,
    output logic              we1,
    output logic [AW-1:0]     wr_reg1,
    output logic [DW-1:0]     wr_data1,
    output logic              we2,
    output logic [AW-1:0]     wr_reg2,
    output logic [DW-1:0]     wr_data2,
    output logic              idle
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int NP = 3;

    // Per-producer status and head views, packed by producer index.
    logic [NP-1:0]    w_full;
    logic [NP-1:0]    w_empty;
    logic [NP-1:0]    w_cand;
    logic [NP-1:0]    w_drop;
    logic [NP-1:0]    w_gnt;
    logic [NP-1:0]    w_pop;
    logic [NP*AW-1:0] w_head_reg;
    logic [NP*DW-1:0] w_head_data;

    // ------------------------------------------------------------------
    // Producer FIFOs. The extra pointer bit separates full from empty.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_fifo
            logic [AW-1:0] r_mem_reg  [DEPTH];
            logic [DW-1:0] r_mem_data [DEPTH];
            logic [PW-1:0] r_wptr;
            logic [PW-1:0] r_rptr;
            logic          w_push;

            assign w_full[gi]  = (r_wptr[PW-1] != r_rptr[PW-1]) &&
                                 (r_wptr[PW-2:0] == r_rptr[PW-2:0]);
            assign w_empty[gi] = (r_wptr == r_rptr);
            assign w_push      = req_valid[gi] & ~w_full[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push)
                        r_wptr <= r_wptr + 1'b1;
                    if (w_pop[gi])
                        r_rptr <= r_rptr + 1'b1;
                end
            end

            // Storage needs no reset: it is only observed when non-empty.
            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem_reg[r_wptr[PW-2:0]]  <= req_reg[gi*AW +: AW];
                    r_mem_data[r_wptr[PW-2:0]] <= req_data[gi*DW +: DW];
                end
            end

            assign w_head_reg[gi*AW +: AW]  = r_mem_reg[r_rptr[PW-2:0]];
            assign w_head_data[gi*DW +: DW] = r_mem_data[r_rptr[PW-2:0]];
            assign w_cand[gi] = ~w_empty[gi] && (w_head_reg[gi*AW +: AW] != '0);
            assign w_drop[gi] = ~w_empty[gi] && (w_head_reg[gi*AW +: AW] == '0);
        end
    endgenerate

    assign req_ready = ~w_full;

    // ------------------------------------------------------------------
    // Selection helpers (index values 0..2 only).
    // ------------------------------------------------------------------
    function automatic logic f_bit(input logic [1:0] s, input logic [NP-1:0] v);
        case (s)
            2'd1:    return v[1];
            2'd2:    return v[2];
            default: return v[0];
        endcase
    endfunction

    function automatic logic [AW-1:0] f_reg(input logic [1:0] s, input logic [NP*AW-1:0] v);
        case (s)
            2'd1:    return v[AW +: AW];
            2'd2:    return v[2*AW +: AW];
            default: return v[0 +: AW];
        endcase
    endfunction

    function automatic logic [DW-1:0] f_data(input logic [1:0] s, input logic [NP*DW-1:0] v);
        case (s)
            2'd1:    return v[DW +: DW];
            2'd2:    return v[2*DW +: DW];
            default: return v[0 +: DW];
        endcase
    endfunction

    function automatic logic [NP-1:0] f_dec(input logic [1:0] s);
        case (s)
            2'd1:    return 3'b010;
            2'd2:    return 3'b100;
            default: return 3'b001;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Round-robin grant
    // ------------------------------------------------------------------
    logic [1:0] r_rr_ptr;
    logic [1:0] w_ord1;
    logic [1:0] w_ord2;
    logic       w_g1_vld;
    logic [1:0] w_g1_idx;
    logic       w_g2_vld;
    logic [1:0] w_g2_idx;
    logic [1:0] w_last;
    logic [1:0] w_rr_next;

    assign w_ord1 = (r_rr_ptr == 2'd2) ? 2'd0 : r_rr_ptr + 2'd1;
    assign w_ord2 = (r_rr_ptr == 2'd0) ? 2'd2 : r_rr_ptr - 2'd1;

    // Port 1 takes the first candidate in priority order; port 2 takes the
    // next candidate whose destination differs. A same-destination
    // candidate is passed over and stays at its head.
    always_comb begin
        w_g1_vld = 1'b0;
        w_g1_idx = 2'd0;
        w_g2_vld = 1'b0;
        w_g2_idx = 2'd0;
        if (f_bit(r_rr_ptr, w_cand)) begin
            w_g1_vld = 1'b1;
            w_g1_idx = r_rr_ptr;
        end
        if (f_bit(w_ord1, w_cand)) begin
            if (!w_g1_vld) begin
                w_g1_vld = 1'b1;
                w_g1_idx = w_ord1;
            end else if (f_reg(w_ord1, w_head_reg) != f_reg(w_g1_idx, w_head_reg)) begin
                w_g2_vld = 1'b1;
                w_g2_idx = w_ord1;
            end
        end
        if (f_bit(w_ord2, w_cand)) begin
            if (!w_g1_vld) begin
                w_g1_vld = 1'b1;
                w_g1_idx = w_ord2;
            end else if (!w_g2_vld &&
                         (f_reg(w_ord2, w_head_reg) != f_reg(w_g1_idx, w_head_reg))) begin
                w_g2_vld = 1'b1;
                w_g2_idx = w_ord2;
            end
        end
    end

    assign w_gnt = (f_dec(w_g1_idx) & {NP{w_g1_vld}}) |
                   (f_dec(w_g2_idx) & {NP{w_g2_vld}});
    // r0 heads leave in the same cycle without occupying a port.
    assign w_pop = w_gnt | w_drop;

    // Port 2, when used, always holds the later index in priority order.
    assign w_last    = w_g2_vld ? w_g2_idx : w_g1_idx;
    assign w_rr_next = (w_last == 2'd2) ? 2'd0 : w_last + 2'd1;

    // ------------------------------------------------------------------
    // Output registers and round-robin pointer
    // ------------------------------------------------------------------
    logic          r_we1;
    logic [AW-1:0] r_wr_reg1;
    logic [DW-1:0] r_wr_data1;
    logic          r_we2;
    logic [AW-1:0] r_wr_reg2;
    logic [DW-1:0] r_wr_data2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr   <= 2'd0;
            r_we1      <= 1'b0;
            r_wr_reg1  <= '0;
            r_wr_data1 <= '0;
            r_we2      <= 1'b0;
            r_wr_reg2  <= '0;
            r_wr_data2 <= '0;
        end else begin
            r_we1 <= w_g1_vld;
            r_we2 <= w_g2_vld;
            if (w_g1_vld) begin
                r_wr_reg1  <= f_reg(w_g1_idx, w_head_reg);
                r_wr_data1 <= f_data(w_g1_idx, w_head_data);
            end
            if (w_g2_vld) begin
                r_wr_reg2  <= f_reg(w_g2_idx, w_head_reg);
                r_wr_data2 <= f_data(w_g2_idx, w_head_data);
            end
            if (w_g1_vld)
                r_rr_ptr <= w_rr_next;
        end
    end

    assign we1      = r_we1;
    assign wr_reg1  = r_wr_reg1;
    assign wr_data1 = r_wr_data1;
    assign we2      = r_we2;
    assign wr_reg2  = r_wr_reg2;
    assign wr_data2 = r_wr_data2;
    assign idle     = (&w_empty) & ~r_we1 & ~r_we2;

`ifdef WB_STALL_CNT_EN
    // ------------------------------------------------------------------
    // Stall counter: back-pressure seen by a producer, or a live head
    // left waiting this cycle.
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = (|(req_valid & w_full)) | (|(w_cand & ~w_gnt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
